// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_stimchk.sv
// Stimulus/check engine for an and4/nand4 cell under test: sweeps all 16 A1..A4
// vectors PASSES times, samples Z after SETTLE cycles and counts mismatches.
module gf180mcu_fd_sc_mcu7t5v0__and4_stimchk #(
    parameter int SETTLE  = 2,
    parameter int PASSES  = 1,
    parameter int ERR_W   = 8,
    parameter bit EXP_INV = 1'b0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    input  logic             Z_CUT,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [3:0]       FAIL_VEC
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       pass_q, pass_d;
    logic [3:0]       a_q, a_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_vld_q, fail_vld_d;
    logic [3:0]       fail_vec_q, fail_vec_d;

    logic start_run;
    logic last_vec;
    logic exp_z;
    logic mismatch;

    assign start_run = ((state_q == S_IDLE) || (state_q == S_FINISH)) && START && !ABORT;
    assign last_vec  = (vec_q == 4'hF) && (pass_q == PASS_LAST);
    assign exp_z     = (&vec_q) ^ EXP_INV;

    // An unknown Z must not silently pass, so only an exact match clears the flag.
    always_comb begin
        mismatch = 1'b1;
        if (Z_CUT == exp_z) mismatch = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RN) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FINISH: if (START) state_d = S_DRIVE;
            S_DRIVE:          if (settle_q == SETTLE_LAST) state_d = S_CHECK;
            S_CHECK:          state_d = last_vec ? S_FINISH : S_DRIVE;
            default:          state_d = S_IDLE;
        endcase
        if (ABORT) state_d = S_IDLE;
    end

    always_comb begin
        BUSY = (state_q == S_DRIVE) || (state_q == S_CHECK);
        DONE = (state_q == S_FINISH);
        PASS = (state_q == S_FINISH) && (err_q == '0);
    end

    // An aborted run keeps its results; only a fresh start clears them.
    always_comb begin
        vec_d      = vec_q;
        settle_d   = settle_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_vec_d = fail_vec_q;
        if (start_run) begin
            vec_d      = '0;
            settle_d   = '0;
            pass_d     = '0;
            err_d      = '0;
            fail_vld_d = 1'b0;
            fail_vec_d = '0;
        end else if (!ABORT) begin
            case (state_q)
                S_DRIVE: settle_d = settle_q + 4'd1;
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                        if (!fail_vld_q) begin
                            fail_vld_d = 1'b1;
                            fail_vec_d = vec_q;
                        end
                    end
                    vec_d    = vec_q + 4'd1;
                    settle_d = '0;
                    if ((vec_q == 4'hF) && !last_vec) pass_d = pass_q + 8'd1;
                end
                default: ;
            endcase
        end
        a_d = ((state_d == S_DRIVE) || (state_d == S_CHECK)) ? vec_d : 4'd0;
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            vec_q      <= '0;
            settle_q   <= '0;
            pass_q     <= '0;
            a_q        <= '0;
            err_q      <= '0;
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            pass_q     <= pass_d;
            a_q        <= a_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    assign A1       = a_q[0];
    assign A2       = a_q[1];
    assign A3       = a_q[2];
    assign A4       = a_q[3];
    assign ERR_CNT  = err_q;
    assign FAIL_VLD = fail_vld_q;
    assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__and4_stimchk.sv
// Bench for the and4 stimulus/check engine: three instances (default, PASSES=3,
// nand4 with SETTLE=1 and ERR_W=2) share controls; each CUT is ideal XOR a fault mask.
module tb_gf180mcu_fd_sc_mcu7t5v0__and4_stimchk;

    logic        CLK   = 1'b0;
    logic        RN    = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [15:0] mask  = '0;

    int nchk = 0;
    int nerr = 0;

    wire       a1_0, a2_0, a3_0, a4_0, busy0, done0, pass0, fvld0;
    wire [7:0] err0;
    wire [3:0] fvec0;
    wire       a1_1, a2_1, a3_1, a4_1, busy1, done1, pass1, fvld1;
    wire [7:0] err1;
    wire [3:0] fvec1;
    wire       a1_2, a2_2, a3_2, a4_2, busy2, done2, pass2, fvld2;
    wire [1:0] err2;
    wire [3:0] fvec2;

    wire [3:0] av0 = {a4_0, a3_0, a2_0, a1_0};
    wire [3:0] av1 = {a4_1, a3_1, a2_1, a1_1};
    wire [3:0] av2 = {a4_2, a3_2, a2_2, a1_2};

    // Cells under test: ideal gate with the mask bit of the applied vector flipping Z
    wire z0 = (&av0) ^ mask[av0];
    wire z1 = (&av1) ^ mask[av1];
    wire z2 = ~(&av2) ^ mask[av2];

    gf180mcu_fd_sc_mcu7t5v0__and4_stimchk #(.SETTLE(2), .PASSES(1), .ERR_W(8), .EXP_INV(1'b0)) u_dut0 (
        .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .Z_CUT(z0),
        .A1(a1_0), .A2(a2_0), .A3(a3_0), .A4(a4_0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .ERR_CNT(err0), .FAIL_VLD(fvld0), .FAIL_VEC(fvec0));

    gf180mcu_fd_sc_mcu7t5v0__and4_stimchk #(.SETTLE(2), .PASSES(3), .ERR_W(8), .EXP_INV(1'b0)) u_dut1 (
        .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .Z_CUT(z1),
        .A1(a1_1), .A2(a2_1), .A3(a3_1), .A4(a4_1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VLD(fvld1), .FAIL_VEC(fvec1));

    gf180mcu_fd_sc_mcu7t5v0__and4_stimchk #(.SETTLE(1), .PASSES(1), .ERR_W(2), .EXP_INV(1'b1)) u_dut2 (
        .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .Z_CUT(z2),
        .A1(a1_2), .A2(a2_2), .A3(a3_2), .A4(a4_2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FAIL_VLD(fvld2), .FAIL_VEC(fvec2));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] m;
        int          e_err;
        bit          e_vld;
        int          e_fv;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Result of the first n checks of a sweep: every masked vector is a mismatch.
    task automatic model(input logic [15:0] m, input int n, input int errw,
                         output int err, output bit vld, output int fv);
        int mx;
        err = 0;
        vld = 1'b0;
        fv  = 0;
        mx  = (1 << errw) - 1;
        for (int k = 0; k < n; k++) begin
            if (m[k % 16]) begin
                if (!vld) fv = k % 16;
                vld = 1'b1;
                err++;
            end
        end
        if (err > mx) err = mx;
    endtask

    task automatic chk_dut(input string t, input logic [31:0] err, input logic vld,
                           input logic [3:0] fv, input logic ps, input logic dn,
                           input logic bs, input logic [3:0] a,
                           input int e_err, input bit e_vld, input int e_fv, input bit e_dn);
        chk({t, ".err_cnt"},  err,        e_err);
        chk({t, ".fail_vld"}, 32'(vld),   32'(e_vld));
        chk({t, ".fail_vec"}, 32'(fv),    e_fv);
        chk({t, ".done"},     32'(dn),    32'(e_dn));
        chk({t, ".pass"},     32'(ps),    32'(e_dn && (e_err == 0)));
        chk({t, ".busy"},     32'(bs),    32'(0));
        chk({t, ".a"},        32'(a),     32'(0));
    endtask

    task automatic chk_all(input string t, input logic [15:0] m, input int n0, input int n1,
                           input int n2, input bit e_dn);
        int  e;
        bit  v;
        int  f;
        model(m, n0, 8, e, v, f);
        chk_dut({t, ".d0"}, 32'(err0), fvld0, fvec0, pass0, done0, busy0, av0, e, v, f, e_dn);
        model(m, n1, 8, e, v, f);
        chk_dut({t, ".d1"}, 32'(err1), fvld1, fvec1, pass1, done1, busy1, av1, e, v, f, e_dn);
        model(m, n2, 2, e, v, f);
        chk_dut({t, ".d2"}, 32'(err2), fvld2, fvec2, pass2, done2, busy2, av2, e, v, f, e_dn);
    endtask

    // One full run; a stray START mid-run must be ignored.
    task automatic do_run(input string t, input logic [15:0] m,
                          input int e0_err, input bit e0_vld, input int e0_fv);
        int d0, d1, d2, abad0, abad2;
        int e;
        bit v;
        int f;
        mask  = m;
        d0    = -1;
        d1    = -1;
        d2    = -1;
        abad0 = 0;
        abad2 = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (c < 48 && (av0 != 4'(c / 3) || !busy0)) abad0++;
            if (c < 32 && (av2 != 4'(c / 2) || !busy2)) abad2++;
            if (done0 && d0 < 0) d0 = c;
            if (done1 && d1 < 0) d1 = c;
            if (done2 && d2 < 0) d2 = c;
            START = (c == 10);
            tick();
        end
        START = 1'b0;
        chk({t, ".latency0"}, d0, 48);
        chk({t, ".latency1"}, d1, 144);
        chk({t, ".latency2"}, d2, 32);
        chk({t, ".walk0_bad_cycles"}, abad0, 0);
        chk({t, ".walk2_bad_cycles"}, abad2, 0);
        chk_dut({t, ".d0"}, 32'(err0), fvld0, fvec0, pass0, done0, busy0, av0,
                e0_err, e0_vld, e0_fv, 1'b1);
        model(m, 48, 8, e, v, f);
        chk_dut({t, ".d1"}, 32'(err1), fvld1, fvec1, pass1, done1, busy1, av1, e, v, f, 1'b1);
        model(m, 16, 2, e, v, f);
        chk_dut({t, ".d2"}, 32'(err2), fvld2, fvec2, pass2, done2, busy2, av2, e, v, f, 1'b1);
    endtask

    initial begin
        logic [15:0] rm;
        int  e;
        bit  v;
        int  f;

        tbl[0] = '{16'h0000, 0,  1'b0, 0};
        tbl[1] = '{16'h7FFF, 15, 1'b1, 0};
        tbl[2] = '{16'h8000, 1,  1'b1, 15};
        tbl[3] = '{16'h0410, 2,  1'b1, 4};
        tbl[4] = '{16'hFFFF, 16, 1'b1, 0};

        RN = 1'b0;
        tick();
        tick();
        chk_all("reset", 16'h0000, 0, 0, 0, 1'b0);
        RN = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            do_run($sformatf("tbl%0d", i), tbl[i].m, tbl[i].e_err, tbl[i].e_vld, tbl[i].e_fv);

        for (int i = 0; i < 6; i++) begin
            rm = 16'($urandom);
            model(rm, 16, 8, e, v, f);
            do_run($sformatf("rnd%0d", i), rm, e, v, f);
        end

        // Abort in CHECK of vector 5 (the nand instance is mid vector 8)
        mask  = 16'h000A;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 17; c++) tick();
        chk("abort.pre_vec", 32'(av0), 32'd5);
        chk("abort.pre_busy", 32'(busy0), 32'd1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk_all("abort", mask, 5, 5, 8, 1'b0);
        tick();
        chk_all("abort_hold", mask, 5, 5, 8, 1'b0);
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        chk_all("start_abort", mask, 5, 5, 8, 1'b0);

        // Reset during DRIVE of vector 9, then a clean run
        mask  = 16'h0003;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 27; c++) tick();
        chk("rst.pre_vec", 32'(av0), 32'd9);
        chk("rst.pre_err", 32'(err0), 32'd2);
        RN = 1'b0;
        tick();
        RN = 1'b1;
        chk_all("midrun_reset", 16'h0000, 0, 0, 0, 1'b0);
        tick();
        do_run("post_rst", 16'h0000, 0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
